// File: rtl/spi_ram_responder.sv
// SPI mode-0 slave emulating a 23LC-style serial SRAM (READ 0x03 / WRITE 0x02).
// All SPI pins are oversampled in clk; a backdoor port preloads the array.
module spi_ram_responder #(
  parameter int DEPTH       = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     spi_clk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     busy,
  output logic                     wr_strobe,
  output logic                     cmd_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [7:0]               load_data
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES:0] sck_sh;
  logic [SYNC_STAGES:0] cs_sh;
  logic [SYNC_STAGES:0] mosi_sh;

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;
  logic mosi;

  logic [4:0]    bit_cnt;
  logic [7:0]    opcode;
  logic [6:0]    shift_in;
  logic [AW-1:0] addr;
  logic [7:0]    tx;
  logic          load_tx;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    op_next;
  logic          op_ok;

  logic [7:0] mem [DEPTH];

  assign sck_rise = sck_sh[SYNC_STAGES-1] & ~sck_sh[SYNC_STAGES];
  assign sck_fall = ~sck_sh[SYNC_STAGES-1] & sck_sh[SYNC_STAGES];
  assign cs_rise  = cs_sh[SYNC_STAGES-1] & ~cs_sh[SYNC_STAGES];
  assign cs_fall  = ~cs_sh[SYNC_STAGES-1] & cs_sh[SYNC_STAGES];
  // MOSI is stable for a full SCK low phase, so the one-older sample is safe
  assign mosi     = mosi_sh[SYNC_STAGES];

  assign op_next = {opcode[6:0], mosi};
  assign op_ok   = (op_next == 8'h02) || (op_next == 8'h03);
  assign busy    = (state != IDLE);

  always_comb begin
    state_d = state;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:
          if (cs_fall) state_d = CMD;
        CMD:
          if (sck_rise && bit_cnt == 5'd7)
            state_d = op_ok ? ADDR : IGNORE;
        ADDR:
          if (sck_rise && bit_cnt == 5'd23)
            state_d = (opcode == 8'h02) ? WR_DATA : RD_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      sck_sh   <= '0;
      // Low reset value hides a CS that is already low at release
      cs_sh    <= '0;
      mosi_sh  <= '0;
      bit_cnt  <= '0;
      opcode   <= '0;
      shift_in <= '0;
      addr     <= '0;
      tx       <= '0;
      load_tx  <= 1'b0;
      spi_miso <= 1'b0;
      wr_strobe <= 1'b0;
      cmd_err  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state     <= state_d;
      sck_sh    <= {sck_sh[SYNC_STAGES-1:0], spi_clk};
      cs_sh     <= {cs_sh[SYNC_STAGES-1:0], spi_cs_n};
      mosi_sh   <= {mosi_sh[SYNC_STAGES-1:0], spi_mosi};
      wr_strobe <= 1'b0;
      cmd_err   <= 1'b0;
      load_tx   <= 1'b0;
      if (load_tx) tx <= mem[addr];
      if (cs_rise) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt  <= '0;
            spi_miso <= 1'b0;
          end
          CMD:
            if (sck_rise) begin
              opcode <= op_next;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                cmd_err <= ~op_ok;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          ADDR:
            if (sck_rise) begin
              addr <= {addr[AW-2:0], mosi};
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                load_tx <= (opcode == 8'h03);
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          WR_DATA:
            if (sck_rise) begin
              shift_in <= {shift_in[5:0], mosi};
              if (bit_cnt == 5'd7) begin
                bit_cnt   <= '0;
                wr_strobe <= 1'b1;
                wr_data   <= {shift_in, mosi};
                wr_addr   <= addr;
                addr      <= addr + AW'(1);
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          RD_DATA:
            if (sck_fall) begin
              spi_miso <= tx[7];
              tx       <= {tx[6:0], 1'b0};
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                addr    <= addr + AW'(1);
                load_tx <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          default:
            spi_miso <= 1'b0;
        endcase
      end
    end
  end

  // SPI commit is the later assignment, so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (wr_strobe) mem[wr_addr] <= wr_data;
  end

endmodule
